// File: rtl/leaf_out_packetizer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : leaf_out_packetizer_pkg                                      |
// | Description : BFT packet field layout, credit constants and packet packer. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package leaf_out_packetizer_pkg;

    localparam int PAYLOAD_BITS       = 32;
    localparam int NUM_LEAF_BITS      = 5;
    localparam int NUM_PORT_BITS      = 4;
    localparam int NUM_ADDR_BITS      = 7;
    localparam int NUM_BRAM_ADDR_BITS = 7;
    localparam int PACKET_BITS        = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;

    localparam int PAYLOAD_LSB = 0;
    localparam int ADDR_LSB    = PAYLOAD_LSB + PAYLOAD_BITS;
    localparam int PORT_LSB    = ADDR_LSB + NUM_ADDR_BITS;
    localparam int LEAF_LSB    = PORT_LSB + NUM_PORT_BITS;
    localparam int VALID_BIT   = LEAF_LSB + NUM_LEAF_BITS;

    // One extra bit so the full buffer depth (2^NUM_BRAM_ADDR_BITS) is representable.
    localparam int                     CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
    localparam logic [CREDIT_BITS-1:0] CREDIT_MAX  = CREDIT_BITS'(1 << NUM_BRAM_ADDR_BITS);

    typedef logic [PACKET_BITS-1:0] packet_t;

    typedef struct packed {
        logic [NUM_LEAF_BITS-1:0] leaf;
        logic [NUM_PORT_BITS-1:0] port;
    } dest_t;

    function automatic packet_t pack_packet(
        input dest_t                    dest,
        input logic [NUM_ADDR_BITS-1:0] addr,
        input logic [PAYLOAD_BITS-1:0]  payload
    );
        return {1'b1, dest.leaf, dest.port, addr, payload};
    endfunction

endpackage
`default_nettype wire

// File: rtl/leaf_out_packetizer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : leaf_out_packetizer_if                                       |
// | Description : User output streams plus BFT egress bus of the packetizer.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface leaf_out_packetizer_if
    import leaf_out_packetizer_pkg::*;
#(
    parameter int NUM_OUT_PORTS = 5
);
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
    logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
    logic                                  resend;
    logic [PACKET_BITS-1:0]                dout_leaf_interface2bft;

    // master: the packetizer; slave: user kernel plus BFT egress
    modport master (
        input  din_leaf_user2interface,
        input  vld_user2interface,
        input  resend,
        output ack_interface2user,
        output dout_leaf_interface2bft
    );

    modport slave (
        output din_leaf_user2interface,
        output vld_user2interface,
        output resend,
        input  ack_interface2user,
        input  dout_leaf_interface2bft
    );
endinterface
`default_nettype wire

// File: rtl/leaf_out_packetizer_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Picks the first request at or after the pointer (one-hot).   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NUM_REQ  = 5,
    parameter int IDX_BITS = 3
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [IDX_BITS-1:0] ptr_i,
    output logic [NUM_REQ-1:0]  grant_o,
    output logic [IDX_BITS-1:0] grant_idx_o,
    output logic                any_grant_o
);
    always_comb begin
        int k;
        k           = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr_i) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!any_grant_o && req_i[k]) begin
                grant_o[k]  = 1'b1;
                grant_idx_o = IDX_BITS'(k);
                any_grant_o = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/leaf_out_packetizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : leaf_out_packetizer                                          |
// | Description : Credit-gated round-robin serialiser of user output streams.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module leaf_out_packetizer
    import leaf_out_packetizer_pkg::*;
#(
    parameter int NUM_OUT_PORTS         = 5,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cfg_vld,
    input  logic [NUM_PORT_BITS-1:0] cfg_port,
    input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
    input  logic                     credit_vld,
    input  logic [NUM_PORT_BITS-1:0] credit_port,
    leaf_out_packetizer_if.master    bus
);
    localparam int PTR_BITS = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    // An update larger than the buffer depth saturates identically to one equal to it.
    localparam int UPD_CLAMP = (FREESPACE_UPDATE_SIZE > int'(CREDIT_MAX)) ? int'(CREDIT_MAX)
                                                                           : FREESPACE_UPDATE_SIZE;

    packet_t                  dout_q, dout_d;
    logic [PTR_BITS-1:0]      rr_ptr_q, rr_ptr_d;

    logic [NUM_OUT_PORTS-1:0] w_eligible;
    logic [NUM_OUT_PORTS-1:0] w_req;
    logic [NUM_OUT_PORTS-1:0] w_grant;
    logic [PTR_BITS-1:0]      w_grant_idx;
    logic                     w_any_grant;
    logic                     w_hold;

    dest_t                    w_dest    [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] w_addr    [NUM_OUT_PORTS];
    logic [PAYLOAD_BITS-1:0]  w_payload [NUM_OUT_PORTS];

    for (genvar p = 0; p < NUM_OUT_PORTS; p++) begin : g_port
        logic                     cfgd_q;
        dest_t                    dest_q;
        logic [CREDIT_BITS-1:0]   credit_q, credit_d;
        logic [NUM_ADDR_BITS-1:0] addr_q;
        logic [CREDIT_BITS:0]     w_credit_sum;
        logic                     w_cfg_hit;
        logic                     w_credit_hit;

        assign w_payload[p]  = bus.din_leaf_user2interface[p*PAYLOAD_BITS +: PAYLOAD_BITS];
        assign w_dest[p]     = dest_q;
        assign w_addr[p]     = addr_q;
        assign w_cfg_hit     = cfg_vld && (cfg_port == NUM_PORT_BITS'(p));
        assign w_credit_hit  = credit_vld && (credit_port == NUM_PORT_BITS'(p));
        assign w_eligible[p] = bus.vld_user2interface[p] & cfgd_q & (credit_q != '0);

        // A grant and an update in the same cycle net out before saturation.
        assign w_credit_sum = {1'b0, credit_q}
                            + (w_credit_hit ? (CREDIT_BITS+1)'(UPD_CLAMP) : '0)
                            - {{CREDIT_BITS{1'b0}}, w_grant[p]};
        assign credit_d     = (w_credit_sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX
                                                                  : w_credit_sum[CREDIT_BITS-1:0];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cfgd_q   <= 1'b0;
                dest_q   <= '0;
                credit_q <= CREDIT_MAX;
                addr_q   <= '0;
            end else if (w_cfg_hit) begin
                cfgd_q   <= 1'b1;
                dest_q   <= '{leaf: cfg_dest_leaf, port: cfg_dest_port};
                credit_q <= CREDIT_MAX;
                addr_q   <= '0;
            end else begin
                credit_q <= credit_d;
                if (w_grant[p]) begin
                    addr_q <= addr_q + NUM_ADDR_BITS'(1);
                end
            end
        end
    end

    assign w_hold = dout_q[VALID_BIT] & bus.resend;
    assign w_req  = w_hold ? '0 : w_eligible;

    rr_arbiter #(
        .NUM_REQ  (NUM_OUT_PORTS),
        .IDX_BITS (PTR_BITS)
    ) u_rr_arbiter (
        .req_i       (w_req),
        .ptr_i       (rr_ptr_q),
        .grant_o     (w_grant),
        .grant_idx_o (w_grant_idx),
        .any_grant_o (w_any_grant)
    );

    always_comb begin
        dout_d   = '0;
        rr_ptr_d = rr_ptr_q;
        if (w_hold) begin
            dout_d = dout_q;
        end else if (w_any_grant) begin
            dout_d   = pack_packet(w_dest[w_grant_idx], w_addr[w_grant_idx], w_payload[w_grant_idx]);
            rr_ptr_d = (w_grant_idx == PTR_BITS'(NUM_OUT_PORTS - 1)) ? '0
                                                                     : w_grant_idx + PTR_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            dout_q   <= dout_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.ack_interface2user      = w_grant;
    assign bus.dout_leaf_interface2bft = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_leaf_out_packetizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_leaf_out_packetizer                                       |
// | Description : Directed plus random bench with a queue-free reference model.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_leaf_out_packetizer;
    localparam int N    = 5;
    localparam int UPD  = 64;
    localparam int CMAX = 128;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_vld;
    logic [3:0]  cfg_port;
    logic [4:0]  cfg_leaf;
    logic [3:0]  cfg_dport;
    logic        credit_vld;
    logic [3:0]  credit_port;
    logic [N-1:0] vld;
    logic [31:0] pay [N];
    logic        resend;

    always #5 clk = ~clk;

    leaf_out_packetizer_if #(.NUM_OUT_PORTS(N)) bus ();
    assign bus.din_leaf_user2interface = {pay[4], pay[3], pay[2], pay[1], pay[0]};
    assign bus.vld_user2interface      = vld;
    assign bus.resend                  = resend;

    leaf_out_packetizer #(
        .NUM_OUT_PORTS         (N),
        .FREESPACE_UPDATE_SIZE (UPD)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_vld       (cfg_vld),
        .cfg_port      (cfg_port),
        .cfg_dest_leaf (cfg_leaf),
        .cfg_dest_port (cfg_dport),
        .credit_vld    (credit_vld),
        .credit_port   (credit_port),
        .bus           (bus)
    );

    int err_n = 0;
    int chk_n = 0;
    int n_ack = 0;

    int          m_credit [N];
    int          m_addr   [N];
    bit          m_cfg    [N];
    int          m_leaf   [N];
    int          m_dport  [N];
    int          m_rr;
    logic [48:0] m_dout;
    logic [N-1:0] exp_ack;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int p = 0; p < N; p++) begin
            m_credit[p] = CMAX;
            m_addr[p]   = 0;
            m_cfg[p]    = 1'b0;
            m_leaf[p]   = 0;
            m_dport[p]  = 0;
        end
        m_rr   = 0;
        m_dout = '0;
    endtask

    // Expected ack for the current inputs; advances the model by one clock.
    task automatic model_cycle();
        int  g;
        bit  hold;
        g       = -1;
        hold    = m_dout[48] && resend;
        exp_ack = '0;
        if (!hold) begin
            for (int i = 0; i < N; i++) begin
                int p;
                p = (m_rr + i) % N;
                if (g < 0 && vld[p] && m_cfg[p] && m_credit[p] > 0) g = p;
            end
        end
        if (hold) begin
            m_dout = m_dout;
        end else if (g >= 0) begin
            exp_ack[g] = 1'b1;
            m_dout = {1'b1, 5'(m_leaf[g]), 4'(m_dport[g]), 7'(m_addr[g]), pay[g]};
            m_addr[g]   = (m_addr[g] + 1) % 128;
            m_rr        = (g + 1) % N;
            m_credit[g] = m_credit[g] - 1;
        end else begin
            m_dout = '0;
        end
        if (credit_vld && credit_port < N) begin
            m_credit[credit_port] = m_credit[credit_port] + UPD;
            if (m_credit[credit_port] > CMAX) m_credit[credit_port] = CMAX;
        end
        if (cfg_vld && cfg_port < N) begin
            m_cfg[cfg_port]    = 1'b1;
            m_leaf[cfg_port]   = int'(cfg_leaf);
            m_dport[cfg_port]  = int'(cfg_dport);
            m_credit[cfg_port] = CMAX;
            m_addr[cfg_port]   = 0;
        end
    endtask

    // Entered just after a falling edge with inputs already driven.
    task automatic step(input string tag);
        #1;
        model_cycle();
        check({tag, "_ack"}, 64'(bus.ack_interface2user), 64'(exp_ack));
        if (bus.ack_interface2user != '0) n_ack++;
        @(posedge clk);
        #1;
        check({tag, "_dout"}, 64'(bus.dout_leaf_interface2bft), 64'(m_dout));
        @(negedge clk);
    endtask

    task automatic idle();
        cfg_vld     = 1'b0;
        cfg_port    = '0;
        cfg_leaf    = '0;
        cfg_dport   = '0;
        credit_vld  = 1'b0;
        credit_port = '0;
        vld         = '0;
        resend      = 1'b0;
        for (int p = 0; p < N; p++) pay[p] = '0;
    endtask

    task automatic rand_pay();
        for (int p = 0; p < N; p++) pay[p] = $urandom;
    endtask

    task automatic configure(input int port, input int leaf, input int dport, input string tag);
        cfg_vld   = 1'b1;
        cfg_port  = 4'(port);
        cfg_leaf  = 5'(leaf);
        cfg_dport = 4'(dport);
        step(tag);
        cfg_vld   = 1'b0;
    endtask

    initial begin
        logic [48:0] first_pkt;
        logic [48:0] held;

        reset_n = 1'b0;
        idle();
        m_reset();
        vld = '1;
        repeat (2) @(negedge clk);
        check("rst_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        check("rst_ack", 64'(bus.ack_interface2user), 64'd0);
        vld = '0;
        reset_n = 1'b1;
        @(negedge clk);

        // First packet: port 0 -> leaf 3 port 2
        configure(0, 3, 2, "cfg0");
        vld[0] = 1'b1;
        pay[0] = 32'hDEADBEEF;
        step("first");
        first_pkt = {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF};
        check("first_pkt", 64'(bus.dout_leaf_interface2bft), 64'(first_pkt));

        // Round robin over three continuously valid ports
        idle();
        configure(1, $urandom_range(0, 31), $urandom_range(0, 15), "cfg1");
        configure(2, $urandom_range(0, 31), $urandom_range(0, 15), "cfg2");
        vld = 5'b00111;
        for (int i = 0; i < 9; i++) begin
            rand_pay();
            step("rr");
        end

        // Credit exhaustion, refill and address wrap on port 0
        idle();
        configure(0, 7, 9, "recfg0");
        n_ack  = 0;
        vld[0] = 1'b1;
        for (int i = 0; i < 129; i++) begin
            rand_pay();
            step("exhaust");
        end
        check("exhaust_acks", 64'(n_ack), 64'd128);
        check("exhaust_valid", 64'(bus.dout_leaf_interface2bft[48]), 64'd0);
        credit_vld  = 1'b1;
        credit_port = 4'd0;
        step("refill");
        credit_vld = 1'b0;
        n_ack = 0;
        rand_pay();
        step("wrap");
        check("wrap_addr", 64'(bus.dout_leaf_interface2bft[38:32]), 64'd0);
        for (int i = 0; i < 64; i++) begin
            rand_pay();
            step("refill_run");
        end
        check("refill_acks", 64'(n_ack), 64'd64);

        // Resend hold for three cycles
        idle();
        vld = 5'b00111;
        rand_pay();
        step("pre_hold");
        rand_pay();
        step("pre_hold");
        held   = bus.dout_leaf_interface2bft;
        resend = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_pay();
            step("hold");
            check("hold_same", 64'(bus.dout_leaf_interface2bft), 64'(held));
        end
        resend = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_pay();
            step("post_hold");
        end

        // Same-cycle grant and update, then update at full credit
        idle();
        configure(1, 1, 1, "recfg1");
        vld[1] = 1'b1;
        for (int i = 0; i < 28; i++) begin
            rand_pay();
            step("drain100");
        end
        credit_vld  = 1'b1;
        credit_port = 4'd1;
        rand_pay();
        step("grant_upd");
        credit_vld = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 129; i++) begin
            rand_pay();
            step("sat_run");
        end
        check("sat_same_cycle_acks", 64'(n_ack), 64'd128);
        vld         = '0;
        credit_vld  = 1'b1;
        credit_port = 4'd1;
        repeat (3) step("upd_full");
        credit_vld = 1'b0;
        vld[1]     = 1'b1;
        n_ack      = 0;
        for (int i = 0; i < 129; i++) begin
            rand_pay();
            step("sat_full_run");
        end
        check("sat_full_acks", 64'(n_ack), 64'd128);

        // Random traffic including out-of-range config/credit ports
        idle();
        for (int i = 0; i < 300; i++) begin
            vld         = 5'($urandom);
            rand_pay();
            credit_vld  = ($urandom_range(0, 3) == 0);
            credit_port = 4'($urandom_range(0, 7));
            resend      = ($urandom_range(0, 3) == 0);
            cfg_vld     = ($urandom_range(0, 31) == 0);
            cfg_port    = 4'($urandom_range(0, 15));
            cfg_leaf    = 5'($urandom);
            cfg_dport   = 4'($urandom);
            step("rand");
        end

        // Asynchronous reset while a packet is held by resend
        idle();
        configure(1, 2, 3, "recfg1b");
        vld[1] = 1'b1;
        rand_pay();
        step("pre_rst");
        check("pre_rst_valid", 64'(bus.dout_leaf_interface2bft[48]), 64'd1);
        resend = 1'b1;
        vld    = '0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        check("async_rst_ack", 64'(bus.ack_interface2user), 64'd0);
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        resend  = 1'b0;
        vld     = '1;
        for (int i = 0; i < 4; i++) begin
            rand_pay();
            step("unconfigured");
        end
        configure(4, 17, 5, "cfg4");
        for (int i = 0; i < 3; i++) begin
            rand_pay();
            step("post_rst");
        end

        $display("Result: errors=%0d of %0d checks", err_n, chk_n);
        $finish;
    end
endmodule
`default_nettype wire
